scanner_link_tx: RTL and testbench

Serial transmitter on the scanner side of the scanner/control-station link, directly upstream of `transferCenter`. It accepts command and binary-payload requests through a small FIFO, frames them into 8-bit frames and drives them MSB-first onto the one-bit line feeding `transferCenter.dataIn`. Frames are aligned to a free-running 3-bit bit counter that starts at reset, matching the receiver's `byteCounter`. Idle frames are 0x00, which the receiver ignores.

---
 rtl/scanner_link_tx_if.sv | 10 +
 rtl/scanner_link_tx.sv | 128 ++++++++++++
 tb/tb_scanner_link_tx.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/scanner_link_tx_if.sv
// rtl/scanner_link_tx_if.sv - request handshake bundle for the scanner link transmitter
interface scanner_link_tx_if;
    logic       req_valid;
    logic       req_kind;
    logic [7:0] req_byte;
    logic       req_ready;

    modport master (output req_valid, output req_kind, output req_byte, input req_ready);
    modport slave  (input req_valid, input req_kind, input req_byte, output req_ready);
endinterface

// File: rtl/scanner_link_tx.sv
// rtl/scanner_link_tx.sv - request FIFO plus MSB-first 8-bit frame serializer feeding transferCenter
module scanner_link_tx #(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    scanner_link_tx_if.slave    req,
    input  logic                link_ready_i,
    output logic                serial_out_o,
    output logic [2:0]          bit_cnt_o,
    output logic                frame_start_o,
    output logic                busy_o,
    output logic                err_illegal_o,
    output logic [CW-1:0]       fifo_count_o
);

    typedef enum logic [1:0] {IDLE, CMD, HDR, PAYLOAD} line_state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;

    line_state_t   state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [6:0]    shift_q;
    logic [7:0]    payload_q;
    logic          serial_q, frame_start_q, busy_q, err_q;

    logic          legal_cmd, accept, push, pop, frame_edge;
    logic [7:0]    frame_d;
    logic [8:0]    head;

    always_comb begin
        legal_cmd = 1'b0;
        case (req.req_byte)
            8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8: legal_cmd = 1'b1;
            default:                                   legal_cmd = 1'b0;
        endcase
    end

    // Readiness comes from the registered count only, so a full FIFO refuses even in a pop cycle.
    assign req.req_ready = (count_q != CW'(FIFO_DEPTH));
    assign accept        = req.req_valid && req.req_ready;
    assign push          = accept && (req.req_kind || legal_cmd);
    assign frame_edge    = (bit_cnt_q == 3'd7);
    assign head          = mem_q[rd_ptr_q];
    assign count_d       = count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        frame_d = 8'h00;
        pop     = 1'b0;
        if (frame_edge) begin
            if (state_q == HDR) begin
                // Header and payload are atomic: link_ready is not consulted here.
                state_d = PAYLOAD;
                frame_d = payload_q;
            end else if ((count_q != '0) && link_ready_i) begin
                pop = 1'b1;
                if (head[8]) begin
                    state_d = HDR;
                    frame_d = 8'h07;
                end else begin
                    state_d = CMD;
                    frame_d = head[7:0];
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {req.req_kind, req.req_byte};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 7'd0;
            payload_q     <= 8'd0;
            serial_q      <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            state_q   <= state_d;
            if (frame_edge) begin
                serial_q      <= frame_d[7];
                shift_q       <= frame_d[6:0];
                frame_start_q <= (state_d != IDLE);
                if (pop && head[8]) payload_q <= head[7:0];
            end else begin
                serial_q      <= shift_q[6];
                shift_q       <= {shift_q[5:0], 1'b0};
                frame_start_q <= 1'b0;
            end
            busy_q <= (count_d != '0) || (state_d != IDLE);
            err_q  <= accept && !req.req_kind && !legal_cmd;
        end
    end

    assign serial_out_o  = serial_q;
    assign bit_cnt_o     = bit_cnt_q;
    assign frame_start_o = frame_start_q;
    assign busy_o        = busy_q;
    assign err_illegal_o = err_q;
    assign fifo_count_o  = count_q;

endmodule

// File: tb/tb_scanner_link_tx.sv
// tb/tb_scanner_link_tx.sv - directed self-checking bench for scanner_link_tx
module tb_scanner_link_tx;

    logic       clk;
    logic       rst;
    logic       link_ready;
    logic       serial_out;
    logic [2:0] bit_cnt;
    logic       frame_start;
    logic       busy;
    logic       err_illegal;
    logic [2:0] fifo_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    scanner_link_tx_if req_if ();

    scanner_link_tx #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req_if),
        .link_ready_i (link_ready),
        .serial_out_o (serial_out),
        .bit_cnt_o    (bit_cnt),
        .frame_start_o(frame_start),
        .busy_o       (busy),
        .err_illegal_o(err_illegal),
        .fifo_count_o (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic offer(input logic kind, input logic [7:0] b);
        req_if.req_valid = 1'b1;
        req_if.req_kind  = kind;
        req_if.req_byte  = b;
    endtask

    task automatic idle_req();
        req_if.req_valid = 1'b0;
        req_if.req_kind  = 1'b0;
        req_if.req_byte  = 8'h00;
    endtask

    task automatic reset_dut();
        idle_req();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] word;
        logic [7:0]  exp_b;
        logic [7:0]  bad [3];
        int          nz;

        rst        = 1'b1;
        link_ready = 1'b1;
        idle_req();

        // Reset state and 32 idle cycles.
        reset_dut();
        check("rst_serial", serial_out, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_if.req_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_err", err_illegal, 0);
        for (int i = 0; i < 32; i++) begin
            check("idle_bit_cnt", bit_cnt, i % 8);
            check("idle_serial", serial_out, 0);
            check("idle_busy", busy, 0);
            check("idle_ready", req_if.req_ready, 1);
            step();
        end

        // Command 0x03 pushed during the first idle frame.
        reset_dut();
        step(); step();
        check("cmd_ready", req_if.req_ready, 1);
        offer(1'b0, 8'h03);
        step();
        idle_req();
        check("cmd_count", fifo_count, 1);
        repeat (5) step();
        check("cmd_frame_start", frame_start, 1);
        check("cmd_busy", busy, 1);
        check("cmd_count_popped", fifo_count, 0);
        exp_b = 8'h03;
        for (int n = 0; n < 8; n++) begin
            check("cmd_bit_cnt", bit_cnt, n);
            check("cmd_serial", serial_out, exp_b[7-n]);
            if (n == 1) check("cmd_frame_start_low", frame_start, 0);
            step();
        end
        check("cmd_after_serial", serial_out, 0);
        check("cmd_after_busy", busy, 0);

        // Binary 0xA5: header then payload, link_ready dropped during the header.
        reset_dut();
        offer(1'b1, 8'hA5);
        step();
        idle_req();
        repeat (7) step();
        word = '0;
        for (int n = 0; n < 16; n++) begin
            if (n == 0) check("bin_hdr_start", frame_start, 1);
            if (n == 8) check("bin_pay_start", frame_start, 1);
            if (n == 2) link_ready = 1'b0;
            word = {word[62:0], serial_out};
            step();
        end
        check("bin_frames", word, 64'h07A5);
        check("bin_after_serial", serial_out, 0);
        check("bin_after_busy", busy, 0);
        link_ready = 1'b1;

        // Fill the FIFO, fifth push refused, then re-offered.
        reset_dut();
        for (int k = 1; k <= 4; k++) begin
            offer(1'b0, k[7:0]);
            step();
        end
        offer(1'b0, 8'h05);
        check("full_ready", req_if.req_ready, 0);
        check("full_count", fifo_count, 4);
        step();
        idle_req();
        check("full_count_hold", fifo_count, 4);
        repeat (3) step();
        check("full_ready_after_pop", req_if.req_ready, 1);
        check("full_count_after_pop", fifo_count, 3);
        word = {63'd0, serial_out};
        offer(1'b0, 8'h05);
        step();
        idle_req();
        check("full_count_refill", fifo_count, 4);
        for (int n = 1; n < 40; n++) begin
            word = {word[62:0], serial_out};
            step();
        end
        check("full_order", word, 64'h0102030405);

        // Illegal command codes.
        reset_dut();
        bad[0] = 8'h07; bad[1] = 8'h00; bad[2] = 8'h09;
        nz = 0;
        for (int k = 0; k < 3; k++) begin
            offer(1'b0, bad[k]);
            if (serial_out !== 1'b0) nz++;
            step();
            idle_req();
            check("illegal_err_pulse", err_illegal, 1);
            check("illegal_count", fifo_count, 0);
            if (serial_out !== 1'b0) nz++;
            step();
            check("illegal_err_clear", err_illegal, 0);
        end
        for (int n = 0; n < 10; n++) begin
            if (serial_out !== 1'b0 || frame_start !== 1'b0 || busy !== 1'b0) nz++;
            step();
        end
        check("illegal_line_idle", nz, 0);
        offer(1'b0, 8'h08);
        step();
        idle_req();
        check("legal8_count", fifo_count, 1);
        check("legal8_err", err_illegal, 0);

        // link_ready held low, raised mid-frame, then reset during the frame.
        reset_dut();
        link_ready = 1'b0;
        offer(1'b0, 8'h06);
        step();
        offer(1'b0, 8'h02);
        step();
        idle_req();
        nz = 0;
        for (int c = 2; c < 20; c++) begin
            if (serial_out !== 1'b0 || busy !== 1'b1 || fifo_count !== 3'd2) nz++;
            step();
        end
        check("hold_idle_frames", nz, 0);
        check("hold_bit_cnt", bit_cnt, 4);
        link_ready = 1'b1;
        repeat (4) step();
        check("release_frame_start", frame_start, 1);
        check("release_count", fifo_count, 1);
        check("release_serial_b7", serial_out, 0);
        repeat (5) step();
        check("release_serial_b2", serial_out, 1);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_serial", serial_out, 0);
        check("mid_rst_bit_cnt", bit_cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ready", req_if.req_ready, 1);
        check("mid_rst_frame_start", frame_start, 0);
        check("mid_rst_err", err_illegal, 0);
        @(negedge clk);
        rst = 1'b0;
        nz = 0;
        for (int n = 0; n < 16; n++) begin
            if (serial_out !== 1'b0 || busy !== 1'b0) nz++;
            step();
        end
        check("post_rst_quiet", nz, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
